// File: rtl/vigenere_pkg.sv
// Shared definitions for the Vigenere stream controller.
// ASCII constants, controller state encoding and a letter test.
package vigenere_pkg;

    localparam logic [7:0] ASCII_A_LO  = 8'd97;
    localparam logic [7:0] ASCII_Z_LO  = 8'd122;
    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_CR    = 8'd13;
    localparam logic [7:0] ASCII_LF    = 8'd10;

    typedef enum logic {
        S_KEYLOAD = 1'b0,
        S_RUN     = 1'b1
    } state_t;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_A_LO) && (c <= ASCII_Z_LO);
    endfunction

endpackage

// File: rtl/vigenere_shift_unit.sv
// Combinational Vigenere letter shift with wrap inside 'a'..'z'.
// Non-letters map to a space.
module vigenere_shift_unit
    import vigenere_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] ch,
    input  logic [4:0]        shift,
    input  logic              decrypt,
    output logic [CHAR_W-1:0] result
);

    logic [CHAR_W:0] wide;
    logic [CHAR_W:0] sum;

    always_comb begin
        wide   = {1'b0, ch};
        sum    = '0;
        result = CHAR_W'(ASCII_SPACE);
        if (is_lower(ch[7:0])) begin
            if (decrypt) begin
                sum = wide - (CHAR_W+1)'(shift);
                if (sum < (CHAR_W+1)'(ASCII_A_LO))
                    sum = sum + (CHAR_W+1)'(26);
            end else begin
                sum = wide + (CHAR_W+1)'(shift);
                if (sum > (CHAR_W+1)'(ASCII_Z_LO))
                    sum = sum - (CHAR_W+1)'(26);
            end
            result = sum[CHAR_W-1:0];
        end
    end

endmodule

// File: rtl/vigenere_stream_ctrl.sv
// Key-load / run sequencer for the Vigenere datapath with a
// registered valid/ready output stage.
module vigenere_stream_ctrl
    import vigenere_pkg::*;
#(
    parameter int KEY_LEN_MAX = 4,
    parameter int CHAR_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_load_req,
    input  logic                     decrypt,
    input  logic                     idx_clr,
    input  logic                     char_valid,
    input  logic [CHAR_W-1:0]        char_in,
    output logic                     in_ready,
    output logic [CHAR_W-1:0]        char_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*KEY_LEN_MAX-1:0] key_arr,
    output logic [3:0]               key_len,
    output logic [2:0]               key_idx,
    output logic                     loading
);

    state_t state, state_n;

    logic [CHAR_W-1:0] key_mem   [8];
    logic [4:0]        shift_mem [8];

    logic              accept;
    logic              is_let;
    logic              is_eol;
    logic              key_full;
    logic              idx_wrap;
    logic [CHAR_W-1:0] shift_res;

    assign accept   = char_valid && in_ready;
    assign is_let   = is_lower(char_in[7:0]);
    assign is_eol   = (char_in[7:0] == ASCII_CR) || (char_in[7:0] == ASCII_LF);
    assign key_full = (key_len + 4'd1) == 4'(KEY_LEN_MAX);
    assign idx_wrap = ({1'b0, key_idx} + 4'd1) == key_len;

    vigenere_shift_unit #(.CHAR_W(CHAR_W)) u_shift (
        .ch      (char_in),
        .shift   (shift_mem[key_idx]),
        .decrypt (decrypt),
        .result  (shift_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_KEYLOAD;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (key_load_req) begin
            state_n = S_KEYLOAD;
        end else if (state == S_KEYLOAD && accept) begin
            if (is_let && key_full)
                state_n = S_RUN;
            else if (is_eol && key_len != 4'd0)
                state_n = S_RUN;
        end
    end

    always_comb begin
        in_ready = !key_load_req && (!out_valid || out_ready);
        loading  = (state == S_KEYLOAD);
    end

    // Key storage and index stepping; a load request wipes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_len <= '0;
            key_idx <= '0;
            for (int i = 0; i < 8; i++) begin
                key_mem[i]   <= '0;
                shift_mem[i] <= '0;
            end
        end else if (key_load_req) begin
            key_len <= '0;
            key_idx <= '0;
            for (int i = 0; i < 8; i++) begin
                key_mem[i]   <= '0;
                shift_mem[i] <= '0;
            end
        end else if (state == S_KEYLOAD) begin
            key_idx <= '0;
            if (accept && is_let) begin
                key_mem[key_len[2:0]]   <= char_in;
                shift_mem[key_len[2:0]] <= 5'(char_in - CHAR_W'(ASCII_A_LO));
                key_len                 <= key_len + 4'd1;
            end
        end else begin
            if (idx_clr)
                key_idx <= '0;
            else if (accept && is_let)
                key_idx <= idx_wrap ? 3'd0 : key_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            char_out  <= CHAR_W'(ASCII_SPACE);
        end else if (key_load_req) begin
            out_valid <= 1'b0;
        end else if (accept && state == S_RUN) begin
            out_valid <= 1'b1;
            char_out  <= shift_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        key_arr = '0;
        for (int i = 0; i < KEY_LEN_MAX; i++)
            key_arr[8*i +: 8] = key_mem[i][7:0];
    end

endmodule

// File: tb/tb_vigenere_stream_ctrl.sv
// Scoreboard bench for vigenere_stream_ctrl: directed cases plus
// randomized traffic against a modular-arithmetic cipher model.
module tb_vigenere_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load_req;
    logic        decrypt;
    logic        idx_clr;
    logic        char_valid;
    logic [7:0]  char_in;
    logic        in_ready;
    logic [7:0]  char_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] key_arr;
    logic [3:0]  key_len;
    logic [2:0]  key_idx;
    logic        loading;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rcv_q[$];
    logic [7:0] key_q[$];
    int         m_idx = 0;
    bit         m_run = 0;
    bit         rnd_done;

    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    vigenere_stream_ctrl #(.KEY_LEN_MAX(4), .CHAR_W(8)) dut (
        .clk          (clk),
        .reset        (rst),
        .key_load_req (key_load_req),
        .decrypt      (decrypt),
        .idx_clr      (idx_clr),
        .char_valid   (char_valid),
        .char_in      (char_in),
        .in_ready     (in_ready),
        .char_out     (char_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .key_arr      (key_arr),
        .key_len      (key_len),
        .key_idx      (key_idx),
        .loading      (loading)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string want);
        string got;
        got = "";
        foreach (rcv_q[i]) got = {got, $sformatf("%c", rcv_q[i])};
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, got, want);
        end
        rcv_q.delete();
    endtask

    function automatic bit lower(input logic [7:0] c);
        return c >= 8'd97 && c <= 8'd122;
    endfunction

    // Reference: classic Vigenere on letter positions modulo 26.
    task automatic model(input logic [7:0] c, input bit dec, input bit clr);
        int k;
        int p;
        if (!m_run) begin
            if (lower(c)) begin
                key_q.push_back(c);
                if (key_q.size() == 4) begin
                    m_run = 1;
                    m_idx = 0;
                end
            end else if ((c == 8'h0D || c == 8'h0A) && key_q.size() > 0) begin
                m_run = 1;
                m_idx = 0;
            end
        end else begin
            if (lower(c)) begin
                k = int'(key_q[m_idx]) - 97;
                p = int'(c) - 97;
                p = dec ? (p - k + 26) % 26 : (p + k) % 26;
                exp_q.push_back(8'(p + 97));
                m_idx = (m_idx + 1) % key_q.size();
            end else begin
                exp_q.push_back(8'h20);
            end
            if (clr) m_idx = 0;
        end
    endtask

    task automatic model_clear();
        key_q.delete();
        exp_q.delete();
        m_run = 0;
        m_idx = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            chk("in_ready", {31'b0, in_ready},
                {31'b0, !key_load_req && (!out_valid || out_ready)});
            if (hold_v) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data", {24'b0, char_out}, {24'b0, hold_d});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", {24'b0, char_out}, 32'hFFFF_FFFF);
                end else begin
                    chk("char_out", {24'b0, char_out}, {24'b0, exp_q.pop_front()});
                    rcv_q.push_back(char_out);
                end
            end
            hold_v <= out_valid && !out_ready && !key_load_req;
            hold_d <= char_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input bit clr = 0);
        bit ok;
        int n;
        char_valid = 1'b1;
        char_in    = c;
        idx_clr    = clr;
        ok = 0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (!ok) stalls++;
            n++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        else model(c, decrypt, clr);
        #1;
        char_valid = 1'b0;
        idx_clr    = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic load_key(input string s, input bit enter);
        send_str(s);
        if (enter) send(8'h0D);
    endtask

    task automatic pulse_klr();
        key_load_req = 1'b1;
        tick();
        key_load_req = 1'b0;
        model_clear();
    endtask

    task automatic pulse_clr();
        idx_clr = 1'b1;
        tick();
        idx_clr = 1'b0;
        if (m_run) m_idx = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 8'(97 + $urandom_range(0, 25));
        case ($urandom_range(0, 4))
            0:       return 8'h20;
            1:       return 8'(48 + $urandom_range(0, 9));
            2:       return 8'h0D;
            3:       return 8'h0A;
            default: return 8'(65 + $urandom_range(0, 25));
        endcase
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key_load_req = 1'b0;
        decrypt = 1'b0;
        idx_clr = 1'b0;
        char_valid = 1'b0;
        char_in = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_len", {28'b0, key_len}, 32'd0);
        chk("rst_key_idx", {29'b0, key_idx}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_char_out", {24'b0, char_out}, 32'h20);
        chk("rst_loading", {31'b0, loading}, 32'd1);
        chk("rst_key_arr", key_arr, 32'd0);
        rst = 1'b0;
        tick();

        load_key("abc", 1);
        chk("abc_key_len", {28'b0, key_len}, 32'd3);
        chk("abc_loading", {31'b0, loading}, 32'd0);
        chk("abc_key_arr", key_arr, 32'h0063_6261);
        stalls = 0;
        send_str("hello");
        chk("hello_stalls", stalls, 32'd0);
        drain();
        chk_str("enc_hello", "hfnlp");

        pulse_klr();
        chk("klr_loading", {31'b0, loading}, 32'd1);
        chk("klr_key_len", {28'b0, key_len}, 32'd0);
        load_key("lem", 0);
        chk("lem_loading", {31'b0, loading}, 32'd1);
        send("o");
        chk("lemo_loading", {31'b0, loading}, 32'd0);
        chk("lemo_key_len", {28'b0, key_len}, 32'd4);
        send_str("attack");
        drain();
        chk_str("enc_attack", "lxfono");
        decrypt = 1'b1;
        pulse_clr();
        chk("clr_key_idx", {29'b0, key_idx}, 32'd0);
        send_str("lxfono");
        drain();
        chk_str("dec_lxfono", "attack");
        decrypt = 1'b0;

        pulse_klr();
        load_key("z", 1);
        send("a");
        send("b");
        decrypt = 1'b1;
        send("a");
        decrypt = 1'b0;
        drain();
        chk_str("wrap_z", "zab");

        pulse_klr();
        load_key("ab", 1);
        chk("nl_idx0", {29'b0, key_idx}, 32'd0);
        send("a");
        chk("nl_idx1", {29'b0, key_idx}, 32'd1);
        send(" ");
        chk("nl_idx2", {29'b0, key_idx}, 32'd1);
        send("9");
        chk("nl_idx3", {29'b0, key_idx}, 32'd1);
        send("b");
        chk("nl_idx4", {29'b0, key_idx}, 32'd0);
        send("b", 1);
        chk("clr_wins_idx", {29'b0, key_idx}, 32'd0);
        drain();
        chk_str("nonletters", "a  cb");

        stalls = 0;
        fork
            send_str("backpres");
            begin
                tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stalled", {31'b0, stalls > 0}, 32'd1);
        chk_str("backpressure", "bbclpset");

        for (int r = 0; r < 4; r++) begin
            int len;
            pulse_klr();
            len = $urandom_range(1, 4);
            send(8'h0D);
            send(8'(48 + $urandom_range(0, 9)));
            for (int i = 0; i < len; i++) send(8'(97 + $urandom_range(0, 25)));
            if (len < 4) send(8'h0A);
            chk("rnd_key_len", {28'b0, key_len}, len);
            chk("rnd_loading", {31'b0, loading}, 32'd0);
            rnd_done = 0;
            fork
                begin
                    for (int i = 0; i < 250; i++) begin
                        decrypt = 1'($urandom_range(0, 1));
                        if ($urandom_range(0, 30) == 0) pulse_clr();
                        send(rand_char());
                    end
                    rnd_done = 1;
                end
                begin
                    while (!rnd_done) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                        tick();
                    end
                    out_ready = 1'b1;
                end
            join
            drain();
            rcv_q.delete();
        end
        decrypt = 1'b0;

        pulse_klr();
        send("q");
        send("r");
        chk("pre_rst_key_len", {28'b0, key_len}, 32'd2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_key_len", {28'b0, key_len}, 32'd0);
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_loading", {31'b0, loading}, 32'd1);
        model_clear();
        tick();
        rst = 1'b0;
        tick();

        load_key("ab", 1);
        out_ready = 1'b0;
        send("c");
        chk("pend_out_valid", {31'b0, out_valid}, 32'd1);
        pulse_klr();
        chk("klr_drop_valid", {31'b0, out_valid}, 32'd0);
        chk("klr_drop_key_len", {28'b0, key_len}, 32'd0);
        chk("klr_drop_key_arr", key_arr, 32'd0);
        chk("klr_drop_loading", {31'b0, loading}, 32'd1);
        out_ready = 1'b1;

        key_load_req = 1'b1;
        char_valid = 1'b1;
        char_in = "a";
        tick();
        key_load_req = 1'b0;
        char_valid = 1'b0;
        chk("klr_blocks_char", {28'b0, key_len}, 32'd0);
        model_clear();

        tick();
        chk("final_queue", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
